// File: rtl/fx_invcdf_tail.sv
`default_nettype none
// ============================================================================
// Module   : fx_invcdf_tail
// Purpose  : Inverse-CDF back end: z = +/-(t - P(t)/Q(t)), t = sqrt(-2 ln p).
// Config   : FX_INVCDF_ROUND_EN selects round-to-nearest multiplies/divide.
// Revision : 1.0 - initial release
// ============================================================================
module fx_invcdf_tail #(
  parameter int WIDTH = 32,
  parameter int QFRAC = 16,
  parameter int QINT  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic signed [WIDTH-1:0] ln_x,
  input  logic                    negate_in,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic signed [WIDTH-1:0] z_out
);

  localparam int NSQ  = (WIDTH + QFRAC) / 2;
  localparam int RADW = 2 * NSQ;
  localparam int REMW = NSQ + 2;
  localparam int LAT  = 1 + NSQ + 5;
  localparam int PW   = 2 * WIDTH;

  localparam logic signed [WIDTH-1:0] C0 = WIDTH'($rtoi(2.515517 * (2.0 ** QFRAC) + 0.5));
  localparam logic signed [WIDTH-1:0] C1 = WIDTH'($rtoi(0.802853 * (2.0 ** QFRAC) + 0.5));
  localparam logic signed [WIDTH-1:0] C2 = WIDTH'($rtoi(0.010328 * (2.0 ** QFRAC) + 0.5));
  localparam logic signed [WIDTH-1:0] D1 = WIDTH'($rtoi(1.432788 * (2.0 ** QFRAC) + 0.5));
  localparam logic signed [WIDTH-1:0] D2 = WIDTH'($rtoi(0.189269 * (2.0 ** QFRAC) + 0.5));
  localparam logic signed [WIDTH-1:0] D3 = WIDTH'($rtoi(0.001308 * (2.0 ** QFRAC) + 0.5));
  localparam logic signed [WIDTH-1:0] ONE_Q   = WIDTH'(64'd1 << QFRAC);
  localparam logic signed [WIDTH-1:0] NEG_TWO = -(ONE_Q <<< 1);
  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef FX_INVCDF_ROUND_EN
  localparam logic signed [PW-1:0]    RND_HALF = PW'(64'd1 << (QFRAC - 1));
`endif

  generate
    if ((QINT != WIDTH - QFRAC) || (((WIDTH + QFRAC) % 2) != 0)) begin : g_param_check
      $error("fx_invcdf_tail: QINT must equal WIDTH-QFRAC and WIDTH+QFRAC must be even");
    end
  endgenerate

  // Q-format multiply: full product, shift out QFRAC, saturate to WIDTH.
  function automatic logic signed [WIDTH-1:0] mulq(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shf;
    logic                 ovf;
    prod = PW'(a) * PW'(b);
`ifdef FX_INVCDF_ROUND_EN
    prod = prod + RND_HALF;
`endif
    shf = prod >>> QFRAC;
    ovf = ~((&shf[PW-1:WIDTH-1]) | ~(|shf[PW-1:WIDTH-1]));
    if (!ovf) begin
      mulq = shf[WIDTH-1:0];
    end else if (shf[PW-1]) begin
      mulq = SAT_MIN;
    end else begin
      mulq = SAT_MAX;
    end
  endfunction

  logic                    en;
  logic [LAT-1:0]          vld_q, vld_d;
  logic [LAT-2:0]          neg_q, neg_d;
  logic signed [WIDTH-1:0] y_q, y_d;

  logic [RADW-1:0] sq_rad_in  [NSQ];
  logic [REMW-1:0] sq_rem_in  [NSQ];
  logic [NSQ-1:0]  sq_root_in [NSQ];
  logic [REMW-1:0] sq_part    [NSQ];
  logic [REMW-1:0] sq_trial   [NSQ];
  logic [NSQ-1:0]  sq_ge;
  logic [RADW-1:0] sq_rad_q   [NSQ-1];
  logic [RADW-1:0] sq_rad_d   [NSQ-1];
  logic [REMW-1:0] sq_rem_q   [NSQ-1];
  logic [REMW-1:0] sq_rem_d   [NSQ-1];
  logic [NSQ-1:0]  sq_root_q  [NSQ];
  logic [NSQ-1:0]  sq_root_d  [NSQ];
  logic signed [WIDTH-1:0] t_sq;

  logic signed [WIDTH-1:0] t1_q, t1_d, p1_q, p1_d, q1_q, q1_d;
  logic signed [WIDTH-1:0] t2_q, t2_d, num_q, num_d, q2_q, q2_d;
  logic signed [WIDTH-1:0] t3_q, t3_d, num3_q, num3_d, den_q, den_d;
  logic signed [WIDTH-1:0] t4_q, t4_d, r_q, r_d;
  logic signed [WIDTH-1:0] z_q, z_d;
  logic [PW-1:0]           div_num, div_den;
  logic signed [WIDTH:0]   w_diff;
  logic signed [WIDTH-1:0] w_pos;

  assign en        = ready_in | ~valid_out;
  assign ready_out = en;
  assign valid_out = vld_q[LAT-1];
  assign z_out     = z_q;

  always_comb begin
    vld_d = {vld_q[LAT-2:0], valid_in};
    neg_d = {neg_q[LAT-3:0], negate_in};
    // Positive log is out of domain; treat it like p = 1 so the lane yields 0.
    if (ln_x > 0) begin
      y_d = '0;
    end else begin
      y_d = mulq(ln_x, NEG_TWO);
    end
  end

  // Restoring square root, one root bit per stage, on the radicand y << QFRAC.
  always_comb begin
    sq_rad_in[0]  = {y_q, {QFRAC{1'b0}}};
    sq_rem_in[0]  = '0;
    sq_root_in[0] = '0;
    for (int k = 1; k < NSQ; k++) begin
      sq_rad_in[k]  = sq_rad_q[k-1];
      sq_rem_in[k]  = sq_rem_q[k-1];
      sq_root_in[k] = sq_root_q[k-1];
    end
    sq_ge = '0;
    for (int k = 0; k < NSQ; k++) begin
      sq_part[k]   = (sq_rem_in[k] << 2) | REMW'(sq_rad_in[k][RADW-1 -: 2]);
      sq_trial[k]  = {sq_root_in[k], 2'b01};
      sq_ge[k]     = (sq_part[k] >= sq_trial[k]);
      sq_root_d[k] = (sq_root_in[k] << 1) | NSQ'(sq_ge[k]);
    end
    for (int k = 0; k < NSQ - 1; k++) begin
      sq_rem_d[k] = sq_ge[k] ? (sq_part[k] - sq_trial[k]) : sq_part[k];
      sq_rad_d[k] = sq_rad_in[k] << 2;
    end
  end

  assign t_sq = WIDTH'(sq_root_q[NSQ-1]);

  always_comb begin
    t1_d   = t_sq;
    p1_d   = C1 + mulq(C2, t_sq);
    q1_d   = D2 + mulq(D3, t_sq);
    t2_d   = t1_q;
    num_d  = C0 + mulq(t1_q, p1_q);
    q2_d   = D1 + mulq(t1_q, q1_q);
    t3_d   = t2_q;
    num3_d = num_q;
    den_d  = ONE_Q + mulq(t2_q, q2_q);
    t4_d   = t3_q;
  end

  // den is never below 1.0 for real data; the zero guard only covers post-reset bubbles.
  always_comb begin
    div_num = {{(WIDTH-QFRAC){1'b0}}, num3_q, {QFRAC{1'b0}}};
`ifdef FX_INVCDF_ROUND_EN
    div_num = div_num + {{(PW-WIDTH+1){1'b0}}, den_q[WIDTH-1:1]};
`endif
    div_den = (den_q == '0) ? PW'(1) : {{WIDTH{1'b0}}, den_q};
    r_d     = WIDTH'(div_num / div_den);
  end

  always_comb begin
    w_diff = $signed({1'b0, t4_q}) - $signed({1'b0, r_q});
    w_pos  = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
    z_d    = neg_q[LAT-2] ? -w_pos : w_pos;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      neg_q <= '0;
      y_q   <= '0;
      for (int k = 0; k < NSQ - 1; k++) begin
        sq_rad_q[k] <= '0;
        sq_rem_q[k] <= '0;
      end
      for (int k = 0; k < NSQ; k++) begin
        sq_root_q[k] <= '0;
      end
      t1_q   <= '0;
      p1_q   <= '0;
      q1_q   <= '0;
      t2_q   <= '0;
      num_q  <= '0;
      q2_q   <= '0;
      t3_q   <= '0;
      num3_q <= '0;
      den_q  <= '0;
      t4_q   <= '0;
      r_q    <= '0;
      z_q    <= '0;
    end else if (en) begin
      vld_q <= vld_d;
      neg_q <= neg_d;
      y_q   <= y_d;
      for (int k = 0; k < NSQ - 1; k++) begin
        sq_rad_q[k] <= sq_rad_d[k];
        sq_rem_q[k] <= sq_rem_d[k];
      end
      for (int k = 0; k < NSQ; k++) begin
        sq_root_q[k] <= sq_root_d[k];
      end
      t1_q   <= t1_d;
      p1_q   <= p1_d;
      q1_q   <= q1_d;
      t2_q   <= t2_d;
      num_q  <= num_d;
      q2_q   <= q2_d;
      t3_q   <= t3_d;
      num3_q <= num3_d;
      den_q  <= den_d;
      t4_q   <= t4_d;
      r_q    <= r_d;
      z_q    <= z_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fx_invcdf_tail.sv
`default_nettype none
// Testbench for fx_invcdf_tail: directed steps with a scoreboard of model results.
module tb_fx_invcdf_tail;

  localparam int LAT = 30;
  localparam longint QMAX = 64'sd2147483647;
  localparam longint QMIN = -64'sd2147483648;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               valid_in;
  logic               ready_out;
  logic signed [31:0] ln_x;
  logic               negate_in;
  logic               valid_out;
  logic               ready_in;
  logic signed [31:0] z_out;

  int checks = 0;
  int errors = 0;
  logic signed [31:0] sb[$];
  logic               stalled_prev = 1'b0;
  logic signed [31:0] held_z = '0;
  logic               got_out = 1'b0;
  logic signed [31:0] last_z = '0;

  always #5 clk = ~clk;

  fx_invcdf_tail #(.WIDTH(32), .QFRAC(16), .QINT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .ln_x      (ln_x),
    .negate_in (negate_in),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .z_out     (z_out)
  );

  function automatic longint mq(input longint a, input longint b);
    longint p;
    p = a * b;
`ifdef FX_INVCDF_ROUND_EN
    p = p + 32768;
`endif
    p = p >>> 16;
    if (p > QMAX) p = QMAX;
    else if (p < QMIN) p = QMIN;
    return p;
  endfunction

  function automatic longint isqrt(input longint v);
    longint r;
    longint c;
    r = 0;
    for (int b = 31; b >= 0; b--) begin
      c = r | (longint'(1) << b);
      if (c * c <= v) r = c;
    end
    return r;
  endfunction

  function automatic logic signed [31:0] model(input logic signed [31:0] ln, input logic ng);
    longint y, t, p1, q1, num, q2, den, dvd, r, w;
    y   = (ln > 0) ? 64'sd0 : mq(longint'(ln), -131072);
    t   = isqrt(y << 16);
    p1  = 52616 + mq(677, t);
    q1  = 12404 + mq(86, t);
    num = 164857 + mq(t, p1);
    q2  = 93899 + mq(t, q1);
    den = 65536 + mq(t, q2);
    dvd = num << 16;
`ifdef FX_INVCDF_ROUND_EN
    dvd = dvd + den / 2;
`endif
    r = dvd / den;
    w = t - r;
    if (w < 0) w = 0;
    return ng ? 32'(-w) : 32'(w);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input logic signed [31:0] obs, input int center);
    logic in_tol;
    in_tol = (obs >= center - 66) && (obs <= center + 66);
    checks++;
    assert (in_tol === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d +-66", tag, obs, center);
    end
  endtask

  // One cycle: drive at posedge+1, observe and score at negedge, then cross the edge.
  task automatic tick(input logic v, input logic signed [31:0] ln, input logic ng,
                      input logic rdy, output logic acc);
    logic signed [31:0] e;
    valid_in  = v;
    ln_x      = ln;
    negate_in = ng;
    ready_in  = rdy;
    @(negedge clk);
    got_out = 1'b0;
    if (stalled_prev) begin
      check("stall_valid", 32'(valid_out), 32'sd1);
      check("stall_hold", z_out, held_z);
    end
    if (valid_out === 1'b1 && ready_in) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'sd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("z_out", z_out, e);
        got_out = 1'b1;
        last_z  = z_out;
      end
    end
    stalled_prev = (valid_out === 1'b1) && !ready_in;
    held_z = z_out;
    acc = v && ready_out;
    if (acc) sb.push_back(model(ln, ng));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int maxc, output int first, output int cnt, output int last);
    logic dummy;
    first = -1;
    cnt   = 0;
    last  = -1;
    for (int k = 1; k <= maxc; k++) begin
      tick(1'b0, 32'sd0, 1'b0, 1'b1, dummy);
      if (got_out) begin
        if (first < 0) first = k;
        cnt++;
        last = k;
      end
      if (sb.size() == 0) break;
    end
    check("drain_empty", 32'(sb.size()), 32'sd0);
  endtask

  task automatic spot(input logic signed [31:0] ln, input logic ng, output int lat);
    logic acc;
    int cnt;
    int last;
    tick(1'b1, ln, ng, 1'b1, acc);
    check("spot_accept", 32'(acc), 32'sd1);
    drain(LAT + 10, lat, cnt, last);
  endtask

  logic signed [31:0] tbl [8];
  logic acc;
  int   lat, cnt, last, sent;
  logic v, r, pre_vo;

  initial begin
    tbl[0] = -32'sd45426;   tbl[1] = -32'sd241755; tbl[2] = -32'sd452706; tbl[3] = 32'sd0;
    tbl[4] = -32'sd100000;  tbl[5] = -32'sd1000000; tbl[6] = 32'sh8000_0000; tbl[7] = 32'sd777;

    rst_n = 1'b0; valid_in = 1'b0; ln_x = '0; negate_in = 1'b0; ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_out", 32'(valid_out), 32'sd0);
    check("rst_z_out", z_out, 32'sd0);
    check("rst_ready_out", 32'(ready_out), 32'sd1);
    rst_n = 1'b1;
    repeat (3) tick(1'b0, 32'sd0, 1'b0, 1'b1, acc);
    check("idle_valid_out", 32'(valid_out), 32'sd0);

    spot(-32'sd45426, 1'b0, lat);
    check("latency", lat, LAT);
    check_tol("p050", last_z, 0);
    spot(-32'sd241755, 1'b1, lat);
    check_tol("p025_neg", last_z, -128450);
    spot(-32'sd241755, 1'b0, lat);
    check_tol("p025_pos", last_z, 128450);
    spot(-32'sd452706, 1'b0, lat);
    check_tol("p001", last_z, 202506);
    spot(32'sd0, 1'b0, lat);
    check("ln_zero", last_z, 32'sd0);
    spot(32'sd12345, 1'b1, lat);
    check("ln_positive", last_z, 32'sd0);
    spot(32'sh8000_0000, 1'b0, lat);
    check("sat_positive", 32'(last_z > 0), 32'sd1);

    // Back-to-back: ten accepts in a row must come out on ten consecutive cycles.
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, tbl[i % 8], i[0], 1'b1, acc);
      check("b2b_accept", 32'(acc), 32'sd1);
    end
    drain(LAT + 20, lat, cnt, last);
    check("b2b_count", cnt, 10);
    check("b2b_span", last - lat + 1, 10);

    sent = 0;
    for (int c = 0; c < 600 && (sent < 8 || sb.size() != 0); c++) begin
      v = (sent < 8) && ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 3) != 0);
      tick(v, tbl[sent % 8], sent[0] ^ sent[1], r, acc);
      if (acc) sent++;
    end
    check("stream_sent", sent, 8);
    check("stream_empty", 32'(sb.size()), 32'sd0);

    // Reset with ten samples in flight and the head sample stalled at the output.
    for (int i = 0; i < 30; i++) begin
      tick(i % 3 == 0, tbl[(i / 3) % 8], 1'b1, 1'b1, acc);
    end
    tick(1'b0, 32'sd0, 1'b0, 1'b0, acc);
    pre_vo = valid_out;
    check("pre_reset_valid", 32'(pre_vo), 32'sd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid_out", 32'(valid_out), 32'sd0);
    check("midrst_z_out", z_out, 32'sd0);
    sb.delete();
    stalled_prev = 1'b0;
    valid_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    spot(-32'sd452706, 1'b1, lat);
    check("post_reset_latency", lat, LAT);
    check_tol("post_reset_value", last_z, -202506);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
